// File: rtl/video_capture_ring_if.sv
// Decoder-side capture bus: SAA7111A byte stream and host controls in,
// RAM write port and frame status out.
interface video_capture_ring_if #(
   parameter int NUM_BANKS = 2,
   parameter int BANK_W    = 1,
   parameter int ADDR_W    = 16
);
   logic                 vref;
   logic                 href;
   logic                 odd;
   logic [7:0]           vpo_y;
   logic                 mode;
   logic                 cap_en;
   logic [NUM_BANKS-1:0] bank_lock;
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [15:0]          wr_data;
   logic                 frame_done;
   logic [BANK_W-1:0]    done_bank;
   logic [BANK_W-1:0]    cur_bank;
   logic                 frame_drop;
   logic                 frame_short;

   modport master (
      output vref, href, odd, vpo_y, mode, cap_en, bank_lock,
      input  wr_en, wr_addr, wr_data, frame_done, done_bank,
      input  cur_bank, frame_drop, frame_short
   );

   modport slave (
      input  vref, href, odd, vpo_y, mode, cap_en, bank_lock,
      output wr_en, wr_addr, wr_data, frame_done, done_bank,
      output cur_bank, frame_drop, frame_short
   );
endinterface

// File: rtl/video_capture_ring.sv
// YCbCr422 capture: decimate odd fields to OUT_W x OUT_H RGB565 and
// write them into a ring of lockable frame banks.
module video_capture_ring #(
   parameter int OUT_W       = 180,
   parameter int OUT_H       = 120,
   parameter int H_DECIM     = 4,
   parameter int V_DECIM     = 2,
   parameter int NUM_BANKS   = 2,
   parameter int BANK_W      = 1,
   parameter int ADDR_W      = 16,
   parameter int BANK_STRIDE = 32768,
   parameter int Y_BLACK     = 95
)(
   input logic                 clk_llc,
   input logic                 reset,
   video_capture_ring_if.slave vid
);

   localparam int HD2 = H_DECIM / 2;
   localparam int GW  = (HD2 > 1) ? $clog2(HD2) : 1;
   localparam int VW  = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;
   localparam int CW  = $clog2(OUT_W + 1);
   localparam int RW  = $clog2(OUT_H + 1);

   logic              fld_q, fld_d;
   logic              href_q, href_d;
   logic              armed_q, armed_d;
   logic              mode_q, mode_d;
   logic [1:0]        ph_q, ph_d;
   logic [GW-1:0]     g_q, g_d;
   logic [VW-1:0]     l_q, l_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              lwr_q, lwr_d;
   logic [7:0]        cb_q, cb_d;
   logic [7:0]        y_q, y_d;
   logic [7:0]        cr_q, cr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              drop_q, drop_d;
   logic              short_q, short_d;
   logic [BANK_W-1:0] dbank_q, dbank_d;
   logic [BANK_W-1:0] cbank_q, cbank_d;

   logic              fld, fld_rise, fld_fall;
   logic              line_end, grp_end, wr_now;
   logic              full, found;
   logic [BANK_W-1:0] nxt_bank, cand;
   logic [15:0]       pix;

   assign fld      = vid.vref & vid.odd;
   assign fld_rise = fld & ~fld_q;
   assign fld_fall = ~fld & fld_q;
   assign line_end = fld & href_q & ~vid.href;
   assign grp_end  = fld & vid.href & (ph_q == 2'd3);
   assign full     = (row_q == RW'(OUT_H));
   assign wr_now   = grp_end & armed_q & (g_q == '0) & (l_q == '0)
                   & (col_q < CW'(OUT_W)) & (row_q < RW'(OUT_H));

   // Pixel conversion from the latched Y0/Cb/Cr of the current group
   always_comb begin
      if (mode_q)
         pix = {y_q[7:3], y_q[7:2], y_q[7:3]};
      else if (y_q <= 8'd180 && cb_q <= 8'd130 && cr_q <= 8'd120)
         pix = 16'h07E0;
      else if (y_q <= 8'd230 && cb_q <= 8'd175 && cr_q >= 8'd145)
         pix = 16'hF800;
      else if (y_q <= 8'd170 && cb_q >= 8'd148 && cr_q <= 8'd163)
         pix = 16'h001F;
      else if (y_q <= 8'(Y_BLACK))
         pix = 16'h0000;
      else
         pix = 16'hFFFF;
   end

   // First unlocked bank after the current one, searching the ring
   always_comb begin
      nxt_bank = cbank_q;
      found    = 1'b0;
      cand     = cbank_q;
      for (int i = 1; i < NUM_BANKS; i++) begin
         cand = BANK_W'((int'(cbank_q) + i) % NUM_BANKS);
         if (!found && !vid.bank_lock[cand]) begin
            nxt_bank = cand;
            found    = 1'b1;
         end
      end
   end

   // Next-state for byte phase, decimation counters and write port
   always_comb begin
      fld_d     = fld;
      href_d    = vid.href;
      armed_d   = armed_q;
      mode_d    = mode_q;
      ph_d      = ph_q;
      g_d       = g_q;
      l_d       = l_q;
      col_d     = col_q;
      row_d     = row_q;
      lwr_d     = lwr_q;
      cb_d      = cb_q;
      y_d       = y_q;
      cr_d      = cr_q;
      wr_en_d   = wr_now;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      drop_d    = 1'b0;
      short_d   = 1'b0;
      dbank_d   = dbank_q;
      cbank_d   = cbank_q;

      if (!vid.href) begin
         ph_d = 2'd0;
         g_d  = '0;
      end else if (fld) begin
         ph_d = ph_q + 2'd1;
         if (grp_end)
            g_d = (g_q == GW'(HD2 - 1)) ? '0 : g_q + GW'(1);
      end

      if (fld & vid.href) begin
         if (ph_q == 2'd0) cb_d = vid.vpo_y;
         if (ph_q == 2'd1) y_d  = vid.vpo_y;
         if (ph_q == 2'd2) cr_d = vid.vpo_y;
      end

      if (wr_now) begin
         wr_data_d = pix;
         wr_addr_d = ADDR_W'(32'(cbank_q) * 32'(BANK_STRIDE)
                   + 32'(row_q) * 32'(OUT_W) + 32'(col_q));
         col_d     = col_q + CW'(1);
         lwr_d     = 1'b1;
      end

      // A kept line only advances row if it actually wrote a pixel
      if (line_end) begin
         l_d   = (l_q == VW'(V_DECIM - 1)) ? '0 : l_q + VW'(1);
         col_d = '0;
         lwr_d = 1'b0;
         if (lwr_q && !full)
            row_d = row_q + RW'(1);
      end

      if (fld_rise) begin
         armed_d = vid.cap_en;
         mode_d  = vid.mode;
         l_d     = '0;
         row_d   = '0;
         col_d   = '0;
         lwr_d   = 1'b0;
      end

      if (fld_fall && armed_q) begin
         armed_d = 1'b0;
         if (full) begin
            done_d  = 1'b1;
            dbank_d = cbank_q;
            drop_d  = ~found;
            cbank_d = nxt_bank;
         end else begin
            short_d = 1'b1;
         end
      end
   end

   // State registers; fld_q resets high so a field already in
   // progress at reset release is not treated as a field start
   always_ff @(posedge clk_llc or posedge reset) begin
      if (reset) begin
         fld_q     <= 1'b1;
         href_q    <= 1'b0;
         armed_q   <= 1'b0;
         mode_q    <= 1'b0;
         ph_q      <= 2'd0;
         g_q       <= '0;
         l_q       <= '0;
         col_q     <= '0;
         row_q     <= '0;
         lwr_q     <= 1'b0;
         cb_q      <= 8'd0;
         y_q       <= 8'd0;
         cr_q      <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 16'd0;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
         short_q   <= 1'b0;
         dbank_q   <= '0;
         cbank_q   <= '0;
      end else begin
         fld_q     <= fld_d;
         href_q    <= href_d;
         armed_q   <= armed_d;
         mode_q    <= mode_d;
         ph_q      <= ph_d;
         g_q       <= g_d;
         l_q       <= l_d;
         col_q     <= col_d;
         row_q     <= row_d;
         lwr_q     <= lwr_d;
         cb_q      <= cb_d;
         y_q       <= y_d;
         cr_q      <= cr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         drop_q    <= drop_d;
         short_q   <= short_d;
         dbank_q   <= dbank_d;
         cbank_q   <= cbank_d;
      end
   end

   assign vid.wr_en       = wr_en_q;
   assign vid.wr_addr     = wr_addr_q;
   assign vid.wr_data     = wr_data_q;
   assign vid.frame_done  = done_q;
   assign vid.done_bank   = dbank_q;
   assign vid.cur_bank    = cbank_q;
   assign vid.frame_drop  = drop_q;
   assign vid.frame_short = short_q;

endmodule
